plru_ctrl: RTL and testbench

- Controller for a 4-way tree-PLRU. It sits between the cache controller and the per-set PLRU flip-flop array.
- Accepts two request types over a valid/ready handshake:
  - touch: mark a hit way as MRU.
  - alloc: return the LRU victim way and mark it MRU.
- Each request is a read-modify-write of one set's 3 tree bits, issued through the array's chip-select/write-enable port.

---
 rtl/plru_ctrl.sv | 134 +++++++++++++
 tb/tb_plru_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/plru_ctrl.sv
// 4-way tree-PLRU controller: read-modify-write of one set's 3 tree bits per
// request (touch = mark hit way MRU, alloc = pick LRU victim and mark it MRU).
module plru_ctrl #(
    parameter int s_index = 4,
    parameter int width   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [s_index-1:0] req_set,
    input  logic [1:0]         req_way,
    output logic               resp_valid,
    output logic [1:0]         resp_way,
    output logic               arr_csb,
    output logic               arr_web,
    output logic [s_index-1:0] arr_addr,
    output logic [width-1:0]   arr_din,
    input  logic [width-1:0]   arr_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [s_index-1:0] set_q, set_d;
    logic [1:0]         way_q, way_d;
    logic [width-1:0]   tree_q, tree_d;
    logic [1:0]         way_eff_q, way_eff_d;

    // bit0 = root, bit1 = pair 0/1, bit2 = pair 2/3; a 0 points at the lower way.
    function automatic logic [1:0] victim(input logic [width-1:0] t);
        if (!t[0]) victim = t[1] ? 2'd1 : 2'd0;
        else       victim = t[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [width-1:0] update(input logic [width-1:0] t,
                                                input logic [1:0]       w);
        update = t;
        unique case (w)
            2'd0: begin update[0] = 1'b1; update[1] = 1'b1; end
            2'd1: begin update[0] = 1'b1; update[1] = 1'b0; end
            2'd2: begin update[0] = 1'b0; update[2] = 1'b1; end
            2'd3: begin update[0] = 1'b0; update[2] = 1'b0; end
            default: update = t;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            set_q     <= '0;
            way_q     <= 2'd0;
            tree_q    <= '0;
            way_eff_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            set_q     <= set_d;
            way_q     <= way_d;
            tree_q    <= tree_d;
            way_eff_q <= way_eff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        op_d      = op_q;
        set_d     = set_q;
        way_d     = way_q;
        tree_d    = tree_q;
        way_eff_d = way_eff_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    set_d = req_set;
                    way_d = req_way;
                end
            end
            READ: begin
                tree_d    = arr_dout;
                way_eff_d = op_q ? victim(arr_dout) : way_q;
            end
            default: ;
        endcase
    end

    // Outputs decode only from registered state, never from req_*.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        arr_csb    = 1'b1;
        arr_web    = 1'b1;
        arr_addr   = '0;
        arr_din    = '0;
        unique case (state_q)
            IDLE: req_ready = 1'b1;
            READ: begin
                arr_csb  = 1'b0;
                arr_addr = set_q;
            end
            WRITE: begin
                arr_csb    = 1'b0;
                arr_web    = 1'b0;
                arr_addr   = set_q;
                arr_din    = update(tree_q, way_eff_q);
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign resp_way = way_eff_q;

endmodule

// File: tb/tb_plru_ctrl.sv
// Directed bench for plru_ctrl with a behavioural PLRU array and
// hand-computed expected tree bits and victims.
module tb_plru_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [3:0] req_set;
    logic [1:0] req_way;
    logic       resp_valid;
    logic [1:0] resp_way;
    logic       arr_csb;
    logic       arr_web;
    logic [3:0] arr_addr;
    logic [2:0] arr_din;
    logic [2:0] arr_dout;

    bit [2:0] mem [16];
    int       wr_cnt = 0;
    int       n_checks = 0;
    int       n_pass = 0;

    always #5 clk = ~clk;

    plru_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_set    (req_set),
        .req_way    (req_way),
        .resp_valid (resp_valid),
        .resp_way   (resp_way),
        .arr_csb    (arr_csb),
        .arr_web    (arr_web),
        .arr_addr   (arr_addr),
        .arr_din    (arr_din),
        .arr_dout   (arr_dout)
    );

    assign arr_dout = mem[arr_addr];

    always @(posedge clk) begin
        if (!arr_csb && !arr_web) begin
            mem[arr_addr] <= arr_din;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One full request from IDLE; returns at the WRITE-cycle negedge.
    task automatic do_req(input logic op, input logic [3:0] set, input logic [1:0] way,
                          input logic [1:0] exp_way, input logic [2:0] exp_din);
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_web", arr_web, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = set;
        req_way   = way;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("read_resp_valid", resp_valid, 0);
        check("read_csb", arr_csb, 0);
        check("read_web", arr_web, 1);
        check("read_addr", arr_addr, set);
        @(negedge clk);
        check("write_resp_valid", resp_valid, 1);
        check("write_resp_way", resp_way, exp_way);
        check("write_web", arr_web, 0);
        check("write_addr", arr_addr, set);
        check("write_din", arr_din, exp_din);
    endtask

    initial begin
        logic [5:0] rdy_pat;
        logic [5:0] rsp_pat;
        int         wc;

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_set = '0; req_way = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_csb", arr_csb, 1);
        check("rst_web", arr_web, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_way", resp_way, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_ready0", req_ready, 1);
        check("idle_resp0", resp_valid, 0);
        check("idle_csb0", arr_csb, 1);
        check("idle_addr0", arr_addr, 0);
        check("idle_din0", arr_din, 0);

        // Four back-to-back allocs on set 5 from 000.
        do_req(1'b1, 4'd5, 2'd0, 2'd0, 3'b011);
        do_req(1'b1, 4'd5, 2'd0, 2'd2, 3'b110);
        do_req(1'b1, 4'd5, 2'd0, 2'd1, 3'b101);
        do_req(1'b1, 4'd5, 2'd0, 2'd3, 3'b000);

        // Touch way 2 on set 3, then alloc on set 3.
        do_req(1'b0, 4'd3, 2'd2, 2'd2, 3'b100);
        do_req(1'b1, 4'd3, 2'd1, 2'd0, 3'b111);

        // req_valid held for 6 cycles; request changes while busy.
        rdy_pat = 6'b001001;
        rsp_pat = 6'b100100;
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b0; req_set = 4'd1; req_way = 2'd1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("hold_ready_c%0d", c), req_ready, rdy_pat[c]);
            check($sformatf("hold_resp_c%0d", c), resp_valid, rsp_pat[c]);
            if (c == 1) begin
                req_op = 1'b1; req_set = 4'd2; req_way = 2'd3;
            end
            if (c == 2) check("hold_way1", resp_way, 1);
            if (c == 5) check("hold_way2", resp_way, 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("hold_set1", mem[1], 3'b001);
        check("hold_set2", mem[2], 3'b011);

        // Bring set 0 to 110, then touch way 1: bit2 must survive.
        do_req(1'b1, 4'd0, 2'd0, 2'd0, 3'b011);
        do_req(1'b1, 4'd0, 2'd0, 2'd2, 3'b110);
        do_req(1'b0, 4'd0, 2'd1, 2'd1, 3'b101);

        // Set 7 to 100, then reset mid-READ of an alloc.
        do_req(1'b0, 4'd7, 2'd2, 2'd2, 3'b100);
        @(negedge clk);
        wc = wr_cnt;
        req_valid = 1'b1; req_op = 1'b1; req_set = 4'd7; req_way = 2'd0;
        @(posedge clk);
        #2;
        check("abort_read_csb", arr_csb, 0);
        check("abort_read_addr", arr_addr, 7);
        #1 rst = 1'b1; req_valid = 1'b0;
        #1;
        check("abort_async_csb", arr_csb, 1);
        check("abort_async_web", arr_web, 1);
        check("abort_async_ready", req_ready, 1);
        check("abort_async_addr", arr_addr, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("abort_web", arr_web, 1);
            check("abort_resp", resp_valid, 0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_resp", resp_valid, 0);
            check("post_web", arr_web, 1);
        end
        check("abort_set7", mem[7], 3'b100);
        check("abort_no_write", wr_cnt, wc);
        check("post_ready", req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
